// File: rtl/micro_sequencer.sv
// Microprogram sequencer: maps an accepted opcode to a micro-PC entry point and
// steps it through end/branch fields of each 44-bit microword from the decode ROM.
module micro_sequencer #(
  parameter int unsigned MAX_STEPS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  opcode,
  input  logic        opcode_valid,
  output logic        opcode_ready,
  input  logic        stall,
  input  logic        flag_z,
  input  logic        flag_c,
  input  logic        flag_n,
  input  logic [43:0] uword,
  output logic [9:0]  uaddr,
  output logic [29:0] ctrl_out,
  output logic        instr_done,
  output logic        fault
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    FAULT
  } state_e;

  localparam logic [9:0] LAST_STEP = 10'(MAX_STEPS - 1);

  state_e      state_q, state_d;
  logic [9:0]  uaddr_q, uaddr_d;
  logic [9:0]  step_q, step_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;
  logic        ready_q, ready_d;

  logic        uend, ubr, cond_hit;
  logic [1:0]  ucond;
  logic [9:0]  utgt;

  assign uend  = uword[43];
  assign ubr   = uword[42];
  assign ucond = uword[41:40];
  assign utgt  = uword[39:30];

  always_comb begin
    case (ucond)
      2'b00:   cond_hit = 1'b1;
      2'b01:   cond_hit = flag_z;
      2'b10:   cond_hit = flag_c;
      default: cond_hit = flag_n;
    endcase
  end

  always_comb begin
    state_d = state_q;
    uaddr_d = uaddr_q;
    step_d  = step_q;
    done_d  = 1'b0;
    fault_d = fault_q;
    case (state_q)
      IDLE: begin
        if (opcode_valid) begin
          uaddr_d = {opcode, 2'b00};
          step_d  = '0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // uend outranks the step limit, so a routine ending on its last allowed word completes cleanly
        if (!stall) begin
          if (uend) begin
            uaddr_d = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (step_q == LAST_STEP) begin
            fault_d = 1'b1;
            uaddr_d = '0;
            state_d = FAULT;
          end else begin
            step_d  = step_q + 10'd1;
            uaddr_d = (ubr && cond_hit) ? utgt : uaddr_q + 10'd1;
          end
        end
      end
      FAULT: begin
        uaddr_d = '0;
      end
      default: begin
        state_d = IDLE;
        uaddr_d = '0;
      end
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      uaddr_q <= '0;
      step_q  <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      uaddr_q <= uaddr_d;
      step_q  <= step_d;
      done_q  <= done_d;
      fault_q <= fault_d;
      ready_q <= ready_d;
    end
  end

  // ROM output already reflects the current micro-PC, so control bits pass straight through
  assign ctrl_out     = (state_q == EXEC && !stall) ? uword[29:0] : '0;
  assign uaddr        = uaddr_q;
  assign opcode_ready = ready_q;
  assign instr_done   = done_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: a vector table for sequencing/branching,
// plus hand-written sequences for step-limit fault and asynchronous reset abort.
module tb_micro_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  opcode;
  logic        opcode_valid, stall, flag_z, flag_c, flag_n;
  logic [43:0] uword, uword_f;
  logic        opcode_ready, instr_done, fault;
  logic        opcode_ready_f, instr_done_f, fault_f;
  logic [9:0]  uaddr, uaddr_f;
  logic [29:0] ctrl_out, ctrl_out_f;

  logic [43:0] rom [1024];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Decode ROM model: latches the address on the falling edge
  always @(negedge clk) begin
    uword   <= rom[uaddr];
    uword_f <= rom[uaddr_f];
  end

  micro_sequencer #(.MAX_STEPS(64)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .opcode_valid(opcode_valid),
    .opcode_ready(opcode_ready), .stall(stall), .flag_z(flag_z), .flag_c(flag_c),
    .flag_n(flag_n), .uword(uword), .uaddr(uaddr), .ctrl_out(ctrl_out),
    .instr_done(instr_done), .fault(fault)
  );

  micro_sequencer #(.MAX_STEPS(4)) dut_f (
    .clk(clk), .rst(rst), .opcode(opcode), .opcode_valid(opcode_valid),
    .opcode_ready(opcode_ready_f), .stall(stall), .flag_z(flag_z), .flag_c(flag_c),
    .flag_n(flag_n), .uword(uword_f), .uaddr(uaddr_f), .ctrl_out(ctrl_out_f),
    .instr_done(instr_done_f), .fault(fault_f)
  );

  typedef struct {
    logic [7:0]  op;
    logic        vld, stl, fz, fc, fn;
    logic [9:0]  ea;
    logic [29:0] ec;
    logic        er, ed;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [43:0] mw(input logic e, input logic b, input logic [1:0] c,
                                     input logic [9:0] t, input logic [29:0] k);
    return {e, b, c, t, k};
  endfunction

  function automatic vec_t v(input logic [7:0] op, input logic vld, input logic stl,
                             input logic fz, input logic fc, input logic fn,
                             input logic [9:0] ea, input logic [29:0] ec,
                             input logic er, input logic ed);
    vec_t r;
    r.op = op; r.vld = vld; r.stl = stl; r.fz = fz; r.fc = fc; r.fn = fn;
    r.ea = ea; r.ec = ec; r.er = er; r.ed = ed;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] op, input logic vld, input logic stl,
                       input logic fz, input logic fc, input logic fn);
    opcode = op; opcode_valid = vld; stall = stl;
    flag_z = fz; flag_c = fc; flag_n = fn;
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = '0;
    rom[10'h014] = mw(0, 0, 2'd0, 10'h000, 30'h1);
    rom[10'h015] = mw(0, 0, 2'd0, 10'h000, 30'h2);
    rom[10'h016] = mw(1, 0, 2'd0, 10'h000, 30'h3);
    rom[10'h040] = mw(0, 1, 2'd1, 10'h200, 30'h40);
    rom[10'h041] = mw(1, 0, 2'd0, 10'h000, 30'h41);
    rom[10'h200] = mw(1, 0, 2'd0, 10'h000, 30'h200);
    rom[10'h044] = mw(0, 1, 2'd0, 10'h300, 30'h44);
    rom[10'h045] = mw(1, 0, 2'd0, 10'h000, 30'h45);
    rom[10'h300] = mw(1, 0, 2'd0, 10'h000, 30'h300);
    rom[10'h048] = mw(0, 1, 2'd2, 10'h310, 30'h48);
    rom[10'h049] = mw(1, 0, 2'd0, 10'h000, 30'h49);
    rom[10'h310] = mw(1, 0, 2'd0, 10'h000, 30'h310);
    rom[10'h04C] = mw(0, 1, 2'd3, 10'h320, 30'h4C);
    rom[10'h04D] = mw(1, 0, 2'd0, 10'h000, 30'h4D);
    rom[10'h320] = mw(1, 0, 2'd0, 10'h000, 30'h320);
    rom[10'h050] = mw(1, 1, 2'd0, 10'h330, 30'h50);
    rom[10'h051] = mw(1, 0, 2'd0, 10'h000, 30'h51);
    rom[10'h330] = mw(1, 0, 2'd0, 10'h000, 30'h330);
    rom[10'h018] = mw(0, 0, 2'd0, 10'h000, 30'h7);
    rom[10'h019] = mw(0, 0, 2'd0, 10'h000, 30'h8);
    rom[10'h01A] = mw(1, 0, 2'd0, 10'h000, 30'h9);
    for (int i = 0; i < 4; i++) rom[10'h3FC + i] = mw(0, 0, 2'd0, 10'h000, 30'hA + 30'(i));
    rom[10'h000] = mw(1, 0, 2'd0, 10'h000, 30'hE);
    for (int i = 0; i < 4; i++) rom[10'h080 + i] = mw(0, 0, 2'd0, 10'h000, 30'h80 + 30'(i));
    rom[10'h084] = mw(1, 0, 2'd0, 10'h000, 30'h84);
    rom[10'h085] = mw(1, 0, 2'd0, 10'h000, 30'h85);
    for (int i = 0; i < 3; i++) rom[10'h090 + i] = mw(0, 0, 2'd0, 10'h000, 30'h90 + 30'(i));
    rom[10'h093] = mw(1, 0, 2'd0, 10'h000, 30'h93);

    //          op    vld stl fz fc fn  uaddr   ctrl     rdy done
    tbl.push_back(v(8'h05, 1, 0, 0, 0, 0, 10'h000, 30'h0,   1, 0));
    tbl.push_back(v(8'h00, 0, 0, 0, 0, 0, 10'h014, 30'h1,   0, 0));
    tbl.push_back(v(8'h00, 0, 0, 0, 0, 0, 10'h015, 30'h2,   0, 0));
    tbl.push_back(v(8'h00, 0, 0, 0, 0, 0, 10'h016, 30'h3,   0, 0));
    tbl.push_back(v(8'h10, 1, 0, 0, 0, 0, 10'h000, 30'h0,   1, 1));
    tbl.push_back(v(8'h00, 0, 0, 1, 0, 0, 10'h040, 30'h40,  0, 0));
    tbl.push_back(v(8'h00, 0, 0, 0, 0, 0, 10'h200, 30'h200, 0, 0));
    tbl.push_back(v(8'h10, 1, 0, 0, 0, 0, 10'h000, 30'h0,   1, 1));
    tbl.push_back(v(8'h00, 0, 0, 0, 0, 0, 10'h040, 30'h40,  0, 0));
    tbl.push_back(v(8'h00, 0, 0, 0, 0, 0, 10'h041, 30'h41,  0, 0));
    tbl.push_back(v(8'h11, 1, 0, 0, 0, 0, 10'h000, 30'h0,   1, 1));
    tbl.push_back(v(8'h00, 0, 0, 0, 0, 0, 10'h044, 30'h44,  0, 0));
    tbl.push_back(v(8'h00, 0, 0, 0, 0, 0, 10'h300, 30'h300, 0, 0));
    tbl.push_back(v(8'h12, 1, 0, 0, 0, 0, 10'h000, 30'h0,   1, 1));
    tbl.push_back(v(8'h00, 0, 0, 0, 1, 0, 10'h048, 30'h48,  0, 0));
    tbl.push_back(v(8'h00, 0, 0, 0, 0, 0, 10'h310, 30'h310, 0, 0));
    tbl.push_back(v(8'h13, 1, 0, 0, 0, 0, 10'h000, 30'h0,   1, 1));
    tbl.push_back(v(8'h00, 0, 0, 1, 1, 0, 10'h04C, 30'h4C,  0, 0));
    tbl.push_back(v(8'h00, 0, 0, 0, 0, 0, 10'h04D, 30'h4D,  0, 0));
    tbl.push_back(v(8'h00, 0, 0, 0, 0, 0, 10'h000, 30'h0,   1, 1));
    tbl.push_back(v(8'h14, 1, 0, 0, 0, 0, 10'h000, 30'h0,   1, 0));
    tbl.push_back(v(8'h00, 0, 0, 1, 1, 1, 10'h050, 30'h50,  0, 0));
    tbl.push_back(v(8'h06, 1, 0, 0, 0, 0, 10'h000, 30'h0,   1, 1));
    tbl.push_back(v(8'h00, 0, 0, 0, 0, 0, 10'h018, 30'h7,   0, 0));
    tbl.push_back(v(8'h00, 0, 1, 0, 0, 0, 10'h019, 30'h0,   0, 0));
    tbl.push_back(v(8'h05, 1, 1, 0, 0, 0, 10'h019, 30'h0,   0, 0));
    tbl.push_back(v(8'h00, 0, 0, 0, 0, 0, 10'h019, 30'h8,   0, 0));
    tbl.push_back(v(8'h00, 0, 0, 0, 0, 0, 10'h01A, 30'h9,   0, 0));
    tbl.push_back(v(8'h00, 0, 0, 0, 0, 0, 10'h000, 30'h0,   1, 1));
    tbl.push_back(v(8'hFF, 1, 0, 0, 0, 0, 10'h000, 30'h0,   1, 0));
    tbl.push_back(v(8'h00, 0, 0, 0, 0, 0, 10'h3FC, 30'hA,   0, 0));
    tbl.push_back(v(8'h00, 0, 0, 0, 0, 0, 10'h3FD, 30'hB,   0, 0));
    tbl.push_back(v(8'h00, 0, 0, 0, 0, 0, 10'h3FE, 30'hC,   0, 0));
    tbl.push_back(v(8'h00, 0, 0, 0, 0, 0, 10'h3FF, 30'hD,   0, 0));
    tbl.push_back(v(8'h00, 0, 0, 0, 0, 0, 10'h000, 30'hE,   0, 0));
    tbl.push_back(v(8'h00, 0, 0, 0, 0, 0, 10'h000, 30'h0,   1, 1));

    rst = 1'b1;
    drive(8'h00, 0, 0, 0, 0, 0);
    #2;
    chk("reset uaddr", 32'(uaddr), 32'h0);
    chk("reset ctrl_out", 32'(ctrl_out), 32'h0);
    chk("reset opcode_ready", 32'(opcode_ready), 32'h1);
    chk("reset instr_done", 32'(instr_done), 32'h0);
    chk("reset fault", 32'(fault), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      cyc();
      drive(tbl[i].op, tbl[i].vld, tbl[i].stl, tbl[i].fz, tbl[i].fc, tbl[i].fn);
      #1;
      chk($sformatf("v%0d uaddr", i), 32'(uaddr), 32'(tbl[i].ea));
      chk($sformatf("v%0d ctrl_out", i), 32'(ctrl_out), 32'(tbl[i].ec));
      chk($sformatf("v%0d opcode_ready", i), 32'(opcode_ready), 32'(tbl[i].er));
      chk($sformatf("v%0d instr_done", i), 32'(instr_done), 32'(tbl[i].ed));
    end

    // Step-limit fault on the MAX_STEPS=4 instance
    cyc();
    drive(8'h00, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    chk("flt pre fault", 32'(fault_f), 32'h0);
    cyc();
    drive(8'h20, 1, 0, 0, 0, 0);
    #1;
    chk("flt accept ready", 32'(opcode_ready_f), 32'h1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      drive(8'h00, 0, 0, 0, 0, 0);
      #1;
      chk($sformatf("flt step%0d uaddr", i), 32'(uaddr_f), 32'h80 + 32'(i));
      chk($sformatf("flt step%0d fault", i), 32'(fault_f), 32'h0);
    end
    for (int i = 0; i < 10; i++) begin
      cyc();
      drive(8'h05, 1, 0, 0, 0, 0);
      #1;
      chk($sformatf("flt hold%0d fault", i), 32'(fault_f), 32'h1);
      chk($sformatf("flt hold%0d ready", i), 32'(opcode_ready_f), 32'h0);
      chk($sformatf("flt hold%0d uaddr", i), 32'(uaddr_f), 32'h0);
      chk($sformatf("flt hold%0d ctrl", i), 32'(ctrl_out_f), 32'h0);
      chk($sformatf("flt hold%0d done", i), 32'(instr_done_f), 32'h0);
    end
    cyc();
    drive(8'h00, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("flt rst fault", 32'(fault_f), 32'h0);
    chk("flt rst ready", 32'(opcode_ready_f), 32'h1);
    rst = 1'b0;

    // uend on the MAX_STEPS-th word completes without fault
    cyc();
    drive(8'h24, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      drive(8'h00, 0, 0, 0, 0, 0);
      #1;
      chk($sformatf("lim step%0d uaddr", i), 32'(uaddr_f), 32'h90 + 32'(i));
    end
    cyc();
    chk("lim done", 32'(instr_done_f), 32'h1);
    chk("lim fault", 32'(fault_f), 32'h0);
    chk("lim ready", 32'(opcode_ready_f), 32'h1);

    // Asynchronous reset in the second EXEC cycle of the linear routine
    cyc();
    drive(8'h05, 1, 0, 0, 0, 0);
    cyc();
    drive(8'h00, 0, 0, 0, 0, 0);
    #1;
    chk("rsm exec1 uaddr", 32'(uaddr), 32'h014);
    cyc();
    chk("rsm exec2 uaddr", 32'(uaddr), 32'h015);
    chk("rsm exec2 ctrl", 32'(ctrl_out), 32'h2);
    rst = 1'b1;
    #1;
    chk("rsm uaddr", 32'(uaddr), 32'h0);
    chk("rsm ctrl", 32'(ctrl_out), 32'h0);
    chk("rsm ready", 32'(opcode_ready), 32'h1);
    chk("rsm done", 32'(instr_done), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("rsm after%0d done", i), 32'(instr_done), 32'h0);
      chk($sformatf("rsm after%0d uaddr", i), 32'(uaddr), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Microprogram sequencer that drives the 10-bit address of the decode ROM. It accepts an 8-bit opcode through a valid/ready handshake, maps it to a microcode entry point, and steps a micro-PC through the routine. Sequencing follows end and branch fields carried in each 44-bit microword. It sits between the instruction fetch/decode front end and the decode ROM, and gates the ROM's control bits out to the datapath.

## Interface
- MAX_STEPS, 64: maximum microinstructions per opcode before a fault is declared (2..1023).
- clk  in  1  system clock. Decode ROM latches its address on the falling edge; this block acts on the rising edge.
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- opcode  in  8  instruction opcode.
- opcode_valid  in  1  opcode is presented.
- opcode_ready  out  1  sequencer can accept an opcode.
- stall  in  1  freeze sequencing. Hold uaddr, suppress ctrl_out.
- flag_z, flag_c, flag_n  in  1 each  datapath condition flags, sampled at the rising edge.
- uword  in  44  decode ROM output for the current uaddr.
- uaddr  out  10  decode ROM address (micro-PC), registered.
- ctrl_out  out  30  datapath control word.
- instr_done  out  1  one-cycle pulse when an opcode routine completes.
- fault  out  1  step limit exceeded. Sticky until rst.

## Operation
- Microword fields:
  - uword[43] uend: last microinstruction.
  - uword[42] ubr: branch enable.
  - uword[41:40] ucond: 00 always, 01 flag_z, 10 flag_c, 11 flag_n.
  - uword[39:30] utgt: branch target.
  - uword[29:0]: control bits.
- States: IDLE, EXEC, FAULT.
- IDLE:
  - opcode_ready=1, uaddr=10'h000, ctrl_out=0.
  - On opcode_valid&&opcode_ready: uaddr<={opcode,2'b00}, step_cnt<=0, go to EXEC.
- EXEC with stall=1: all registers hold. ctrl_out=0. instr_done=0.
- EXEC with stall=0: ctrl_out=uword[29:0]. At the rising edge, in priority order:
  1. uend=1: uaddr<=0, instr_done<=1, go to IDLE.
  2. Else if step_cnt==MAX_STEPS-1: fault<=1, uaddr<=0, go to FAULT.
  3. Else if ubr=1 and the selected condition is true: uaddr<=utgt.
  4. Else: uaddr<=uaddr+1, mod 1024, so 10'h3FF wraps to 10'h000.
  - step_cnt increments on every non-terminal step.
- uend takes precedence over ubr in the same word. uend on the MAX_STEPS-th word completes normally with no fault.
- FAULT: opcode_ready=0, ctrl_out=0, uaddr=0. Only rst exits this state.
- opcode_valid is ignored outside IDLE. A new opcode is never accepted on the same edge that ends a routine.
- step_cnt is 10 bits wide.

## Timing
- Reset values (asynchronous): state=IDLE, uaddr=0, step_cnt=0, fault=0, instr_done=0, opcode_ready=1, ctrl_out=0.
- uaddr updates at rising edge k. The ROM latches it at the falling edge of k, so uword is valid before rising edge k+1. Each microstep therefore takes exactly one clock, with no wait state after accept or after a branch.
- Accept edge to first ctrl_out of the routine: 1 cycle. An N-word routine occupies EXEC for N unstalled cycles.
- instr_done is registered. It is high for exactly the first IDLE cycle after the uend edge, and opcode_ready is also high in that cycle. Minimum spacing between accepts is N+1 cycles.
- stall is sampled at the rising edge. A stalled cycle adds exactly one cycle and does not advance step_cnt.
- An rst assertion during EXEC aborts immediately: uaddr=0, no instr_done pulse.

## Test plan
- Linear routine: load ROM 0x014..0x016 with uend=0,0,1 and controls 0x1,0x2,0x3. Send opcode 0x05. Required: uaddr sequence 0x014,0x015,0x016,0x000; ctrl_out 0x1,0x2,0x3; instr_done one cycle after 0x016; opcode_ready low for 3 cycles.
- Conditional branch: word 0x040 has ubr=1, ucond=01, utgt=0x200.
  - flag_z=1: next uaddr=0x200.
  - flag_z=0: next uaddr=0x041.
  - ucond=00: branch taken regardless of flags.
- Stall: assert stall for 2 cycles during the second word of a 3-word routine. Required: uaddr holds, ctrl_out=0 while stalled, routine completes in 5 cycles, instr_done still pulses once.
- Wrap and precedence:
  - opcode 0xFF with 0x3FF not uend: next uaddr=0x000.
  - A word with both uend=1 and a taken branch: returns to IDLE, not to utgt.
- Fault: MAX_STEPS=4, 6-word routine with no uend in the first 4 words. Required: fault=1 after the 4th step, uaddr=0, opcode_ready stays 0 through 10 cycles of opcode_valid=1 and ignores them. rst clears fault.
- Reset mid-operation: assert rst asynchronously in the 2nd EXEC cycle, between edges. Required: uaddr=0, ctrl_out=0, opcode_ready=1 immediately, and no instr_done pulse.
